// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned shift-add multiplier owning the Hi/Lo pair.
// A MULTU request is taken in IDLE, one partial product is folded in per
// clock for WIDTH clocks, and the full product is committed to HiOut/LoOut
// on the final iteration edge. Hi/Lo otherwise hold the last result.
//
// Handshake: a request is the pair (start && Signal == MULTU). It is accepted
// only on a rising edge where busy is low (state IDLE); busy is the inverse
// "ready" and rises the cycle after acceptance. Requests seen while busy, or
// with any other funct code, are dropped without effect. done is a one-cycle
// pulse marking the edge on which Hi/Lo were rewritten.
module multu_hilo #(
   parameter logic [5:0] MULTU = 6'b011001,
   parameter int         WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic [0:0]       state_dbg
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [0:0]         state;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic               req;

   // Upper-half sum keeps the carry bit so all-ones operands stay exact.
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] next_prod;

   assign req       = start && (Signal == MULTU);
   assign busy      = (state == RUN);
   assign state_dbg = state;

   // One shift-add step: conditionally add the multiplicand into the upper
   // half, then shift the whole product right with the carry entering the MSB.
   always_comb begin
      upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) begin
         upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      end
      next_prod = {upper_sum, prod[WIDTH-1:1]};
   end

   // Control FSM, iteration datapath and Hi/Lo commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         mcand <= '0;
         prod  <= '0;
         done  <= 1'b0;
         HiOut <= '0;
         LoOut <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  mcand <= dataA;
                  prod  <= {{WIDTH{1'b0}}, dataB};
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               prod  <= next_prod;
               count <= count + 1'b1;
               if (count == LAST) begin
                  HiOut <= next_prod[2*WIDTH-1:WIDTH];
                  LoOut <= next_prod[WIDTH-1:0];
                  done  <= 1'b1;
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed bench for multu_hilo: hand-computed products, busy/done timing,
// Hi/Lo hold while iterating, ignored requests and mid-run reset.
module tb_multu_hilo;

   localparam logic [5:0] multu_fn = 6'b011001;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic [5:0]  signal;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic [0:0]  state_dbg;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_res = 64'h0;

   // Clock.
   always #5 clk = ~clk;

   multu_hilo dut (
      .clk       (clk),
      .reset     (reset),
      .dataA     (data_a),
      .dataB     (data_b),
      .Signal    (signal),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .HiOut     (hi_out),
      .LoOut     (lo_out),
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive a one-cycle request, sampled on the next rising edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
      @(negedge clk);
      data_a = a;
      data_b = b;
      signal = sig;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Run one multiply and score it. inject_at > 0 pulses a stray all-ones
   // request on that busy cycle, which must not disturb the running multiply.
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int inject_at);
      int          busy_cnt = 0;
      int          done_cnt = 0;
      int          hold_err = 0;
      int          cyc      = 0;
      bit          seen     = 0;
      logic [63:0] got      = 64'h0;
      logic [63:0] want;
      exp_q.push_back(exp);
      issue(a, b, multu_fn);
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == inject_at) begin
            data_a = 32'hFFFF_FFFF;
            data_b = 32'hFFFF_FFFF;
            signal = multu_fn;
            start  = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (busy) begin
            busy_cnt++;
            if ({hi_out, lo_out} !== last_res) hold_err++;
         end
         if (done) begin
            done_cnt++;
            seen = 1;
            got  = {hi_out, lo_out};
         end
      end
      start = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
      want = exp_q.pop_front();
      check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "/hold"}, 64'(hold_err), 64'd0);
      check({tag, "/product"}, got, want);
      check({tag, "/after"}, {hi_out, lo_out}, want);
      check({tag, "/idle"}, {63'd0, busy}, 64'd0);
      last_res = want;
   endtask

   initial begin
      int busy_seen;
      int done_seen;
      reset  = 1'b1;
      start  = 1'b0;
      data_a = '0;
      data_b = '0;
      signal = '0;

      // Reset then idle.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      busy_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) done_seen++;
         if ({hi_out, lo_out} !== 64'h0) busy_seen += 100;
      end
      check("reset/hilo", {hi_out, lo_out}, 64'h0);
      check("reset/busy_done", 64'(busy_seen + done_seen), 64'd0);

      // Basic and carry extremes.
      run_mul("basic_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
      run_mul("ones_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
      run_mul("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);
      run_mul("ones_x2", 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 0);

      // Wrong funct code is ignored.
      issue(32'd11, 32'd13, 6'b100000);
      busy_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) done_seen++;
      end
      check("bad_funct/busy", 64'(busy_seen), 64'd0);
      check("bad_funct/done", 64'(done_seen), 64'd0);
      check("bad_funct/hilo", {hi_out, lo_out}, last_res);

      // Stray request during RUN.
      run_mul("ignore_7x9", 32'd7, 32'd9, 64'h0000_0000_0000_003F, 5);

      // Hold previous result while iterating.
      run_mul("prior_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
      run_mul("hold_1e4sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0);

      // Reset mid-operation.
      issue(32'h0000_1234, 32'h0000_5678, multu_fn);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst/hilo", {hi_out, lo_out}, 64'h0);
      check("midrst/busy_done", {62'd0, busy, done}, 64'd0);
      last_res  = 64'h0;
      busy_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) done_seen++;
      end
      check("midrst/no_busy", 64'(busy_seen), 64'd0);
      check("midrst/no_done", 64'(done_seen), 64'd0);
      run_mul("after_rst_2x3", 32'd2, 32'd3, 64'h0000_0000_0000_0006, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32x32 unsigned shift-add multiplier that owns the Hi/Lo register pair of the datapath. It sits directly upstream of the result-select mux: its HiOut/LoOut outputs are the values that mux returns for MFHI/MFLO. Accepts a MULTU request, iterates one partial product per cycle for 32 cycles, then commits the 64-bit product into Hi/Lo. Hi/Lo hold their value until the next completed multiply.

## Interface
Parameters:
- MULTU, 6'b011001, funct code that starts a multiply.
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is required to work.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- dataA  in  32  multiplicand, sampled only on the accepting edge.
- dataB  in  32  multiplier, sampled only on the accepting edge.
- Signal  in  6  funct code; a request is Signal == MULTU.
- start  in  1  request strobe, qualified by Signal.
- busy  out  1  high while a multiply is iterating.
- done  out  1  one-cycle pulse; Hi/Lo were updated on the edge that raised it.
- HiOut  out  32  committed product[63:32].
- LoOut  out  32  committed product[31:0].

## Operation
- States: IDLE, RUN. done is a separate registered flag, not a state.
- Accept: in IDLE, start==1 and Signal==MULTU -> latch mcand=dataA, prod={32'b0, dataB}, count=0, go RUN.
- start with any other Signal value: ignored, no state change.
- start while in RUN: ignored; operands of the running multiply are unaffected.
- RUN iteration (per edge): if prod[0]==1, upper = prod[63:32] + mcand as 33-bit sum (carry kept), else upper = {1'b0, prod[63:32]}; prod <= {upper, prod[31:1]} (shift right one, carry enters bit 63). count increments.
- Iteration width rule: the 33-bit add must never drop the carry; 0xFFFFFFFF*0xFFFFFFFF must be exact.
- Completion: on the edge performing iteration 32 (count==31), the final product is written to HiOut/LoOut, state -> IDLE, done <= 1.
- done cleared on every edge where completion does not occur.
- HiOut/LoOut never change except at completion or reset; reading during RUN returns the previous result.
- Reset (any state, including mid-RUN): state IDLE, count 0, prod 0, mcand 0, busy 0, done 0, HiOut 0, LoOut 0. Partial work is discarded.
- Reset and start on the same edge: reset wins; request is lost.

## Timing
- Reset values: busy 0, done 0, HiOut 32'h0, LoOut 32'h0.
- busy = (state == RUN), combinational from state register.
- Accepting edge E0: busy rises after E0.
- Iterations on E1..E32; at E32 HiOut/LoOut update, busy falls, done rises.
- done high exactly one cycle (E32 to E33).
- Latency: start sampled at E0 -> result visible after E32 (32 cycles); busy high exactly 32 cycles.
- Back-to-back: a new request may be sampled at E33 (the done cycle, state IDLE); its result appears after E65. Throughput one multiply per 33 cycles.
- No combinational path from dataA/dataB/start to any output.

## Test plan
- Reset then idle: hold reset 2 cycles, release -> HiOut=0, LoOut=0, busy=0, done=0 for 5 further cycles.
- Basic: dataA=3, dataB=5, Signal=MULTU, start 1 cycle -> busy high 32 cycles, done pulses once, HiOut=0x00000000, LoOut=0x0000000F.
- Carry extreme: 0xFFFFFFFF * 0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001; then 0x80000000 * 2 -> HiOut=0x00000001, LoOut=0x00000000.
- Ignored requests: start with Signal=6'b100000 -> busy stays 0; during RUN of 7*9, pulse start with dataA=dataB=0xFFFFFFFF -> result still Hi=0, Lo=63, single done.
- Hold during RUN: prior result Hi=0, Lo=15, start 0x10000*0x10000 -> HiOut/LoOut read 0/15 every busy cycle, then Hi=0x00000001, Lo=0 with done.
- Reset mid-operation: start 0x1234*0x5678, assert reset at iteration 10 -> all outputs 0 next cycle, no done pulse; new 2*3 afterwards -> Lo=6 after exactly 32 busy cycles.
